// File: rtl/updown_mod_counter_pkg.sv
// Shared helpers for the up/down modulo counter: parameter legality and terminal value.
package updown_mod_counter_pkg;

  function automatic bit params_ok(input longint width, input longint modulus, input longint init);
    longint span_v;
    if ((width < 64'sd1) || (width > 64'sd32)) begin
      return 1'b0;
    end
    span_v = 64'sd1 <<< width;
    return (modulus >= 64'sd2) && (modulus <= span_v) && (init >= 64'sd0) && (init < modulus);
  endfunction

  function automatic longint term_value(input longint modulus);
    return modulus - 64'sd1;
  endfunction

endpackage

// File: rtl/updown_mod_counter_mod_incdec.sv
// Next-count logic: modulo increment/decrement with wrap detection at WIDTH+1 bits.
module mod_incdec
  import updown_mod_counter_pkg::*;
#(
  parameter int     WIDTH   = 32'sd4,
  parameter longint MODULUS = 64'sd16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);

  localparam int               W1      = WIDTH + 32'sd1;
  localparam logic [WIDTH:0]   MOD_EXT = W1'(MODULUS);
  localparam logic [WIDTH:0]   ONE_EXT = W1'(32'sd1);
  localparam logic [WIDTH-1:0] TERM    = WIDTH'(term_value(MODULUS));

  logic [WIDTH:0] count_ext_s;
  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  // Up wraps when count+1 reaches MODULUS; down wraps on the borrow out of 0.
  always_comb begin
    count_ext_s = {1'b0, count};
    sum_s       = count_ext_s + ONE_EXT;
    diff_s      = count_ext_s - ONE_EXT;
    if (up) begin
      wrap = (sum_s == MOD_EXT);
      if (wrap) begin
        next = '0;
      end else begin
        next = sum_s[WIDTH-1:0];
      end
    end else begin
      wrap = diff_s[WIDTH];
      if (wrap) begin
        next = TERM;
      end else begin
        next = diff_s[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous load, out-of-range load clamp and sticky error.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int     WIDTH   = 32'sd4,
  parameter longint MODULUS = 64'sd16,
  parameter longint INIT    = 64'sd0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             TC,
  output logic             ERR
);

  localparam int               W1      = WIDTH + 32'sd1;
  localparam logic [WIDTH:0]   MOD_EXT = W1'(MODULUS);
  localparam logic [WIDTH-1:0] TERM    = WIDTH'(term_value(MODULUS));
  localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT);

  generate
    if (!params_ok(WIDTH, MODULUS, INIT)) begin : g_bad_params
      $error("updown_mod_counter: illegal WIDTH/MODULUS/INIT combination");
    end
  endgenerate

  logic [WIDTH-1:0] count_r;
  logic             err_r;
  logic [WIDTH-1:0] next_s;
  logic             wrap_s;
  logic [WIDTH-1:0] load_val_s;
  logic             load_bad_s;

  mod_incdec #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_incdec (
    .count (count_r),
    .up    (UP),
    .next  (next_s),
    .wrap  (wrap_s)
  );

  // Clamp out-of-range load values to the terminal value.
  always_comb begin
    load_bad_s = ({1'b0, DATA} >= MOD_EXT);
    if (load_bad_s) begin
      load_val_s = TERM;
    end else begin
      load_val_s = DATA;
    end
  end

  // Count and sticky-error registers: reset > load > count > hold.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_r <= INIT_V;
      err_r   <= 1'b0;
    end else if (LOAD) begin
      count_r <= load_val_s;
      err_r   <= err_r | load_bad_s;
    end else if (CE) begin
      count_r <= next_s;
    end
  end

  assign O    = count_r;
  assign ERR  = err_r;
  assign TC   = wrap_s;
  assign COUT = wrap_s & CE & ~LOAD & ~RESET;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: driver queues hand-computed per-cycle expectations, monitor compares at negedge.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst10 = 1'b0, ce10 = 1'b0, up10 = 1'b0, ld10 = 1'b0;
  logic [3:0] data10 = 4'd0;
  logic [3:0] o10;
  logic       cout10, tc10, err10;

  logic       rst16 = 1'b0, ce16 = 1'b0, up16 = 1'b0, ld16 = 1'b0;
  logic [3:0] data16 = 4'd0;
  logic [3:0] o16;
  logic       cout16, tc16, err16;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .INIT(0)) dut10 (
    .CLK(clk), .RESET(rst10), .CE(ce10), .UP(up10), .LOAD(ld10), .DATA(data10),
    .O(o10), .COUT(cout10), .TC(tc10), .ERR(err10)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .INIT(5)) dut16 (
    .CLK(clk), .RESET(rst16), .CE(ce16), .UP(up16), .LOAD(ld16), .DATA(data16),
    .O(o16), .COUT(cout16), .TC(tc16), .ERR(err16)
  );

  typedef struct {
    int sel;
    bit chk;
    int o;
    bit err;
    bit tc;
    bit cout;
    int step;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_cnt = 0;

  task automatic check(input string nm, input int step, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s step %0d got %0d want %0d", nm, step, got, want);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        if (e.sel == 0) begin
          check("O10", e.step, int'(o10), e.o);
          check("ERR10", e.step, int'(err10), int'(e.err));
          check("TC10", e.step, int'(tc10), int'(e.tc));
          check("COUT10", e.step, int'(cout10), int'(e.cout));
          check("O10_range", e.step, int'(o10 < 4'd10), 1);
        end else begin
          check("O16", e.step, int'(o16), e.o);
          check("ERR16", e.step, int'(err16), int'(e.err));
          check("TC16", e.step, int'(tc16), int'(e.tc));
          check("COUT16", e.step, int'(cout16), int'(e.cout));
        end
      end
    end
  end

  // Apply one cycle of inputs and queue what the outputs must show during that cycle.
  task automatic v(input int sel, input bit r, input bit ce, input bit up, input bit ld,
                   input int data, input bit chk, input int o, input bit err,
                   input bit tc, input bit cout);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel == 0) begin
      rst10 = r; ce10 = ce; up10 = up; ld10 = ld; data10 = 4'(data);
    end else begin
      rst16 = r; ce16 = ce; up16 = up; ld16 = ld; data16 = 4'(data);
    end
    e.sel = sel; e.chk = chk; e.o = o; e.err = err; e.tc = tc; e.cout = cout; e.step = step_cnt;
    q.push_back(e);
    step_cnt++;
  endtask

  initial begin
    int  m_o;
    bit  m_err;
    bit  r, ce, up, ld, tc;
    int  data;
    int  wait_cyc;

    // MODULUS=10: reset, count up 12 cycles
    v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      v(0, 0, 1, 1, 0, 0, 1, i % 10, 0, (i % 10) == 9, (i % 10) == 9);
    end
    // load 3, count down 5 cycles through the 0 -> 9 wrap
    v(0, 0, 0, 1, 1, 3, 1, 2, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1);
    v(0, 0, 1, 0, 0, 0, 1, 9, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    // reach 9, flip UP in the same cycle, then hold
    v(0, 0, 1, 1, 0, 0, 1, 8, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1, 9, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    // out-of-range load, sticky ERR, reset clears
    v(0, 0, 0, 0, 1, 12, 1, 8, 0, 0, 0);
    v(0, 0, 0, 1, 1, 2, 1, 9, 1, 1, 0);
    v(0, 1, 1, 1, 0, 0, 1, 2, 1, 0, 0);
    v(0, 0, 1, 0, 1, 9, 1, 0, 0, 1, 0);
    v(0, 1, 1, 1, 0, 0, 1, 9, 0, 1, 0);
    v(0, 0, 0, 1, 1, 10, 1, 0, 0, 0, 0);
    v(0, 0, 1, 1, 0, 0, 1, 9, 1, 1, 1);
    v(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    v(0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0);

    // MODULUS=16, INIT=5
    v(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    v(1, 0, 0, 1, 1, 14, 1, 5, 0, 0, 0);
    v(1, 0, 1, 1, 0, 0, 1, 14, 0, 0, 0);
    v(1, 0, 1, 1, 0, 0, 1, 15, 0, 1, 1);
    v(1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    v(1, 1, 1, 0, 1, 7, 1, 1, 0, 0, 0);
    v(1, 0, 1, 0, 0, 0, 1, 5, 0, 0, 0);
    v(1, 0, 0, 0, 1, 0, 1, 4, 0, 0, 0);
    v(1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1);
    v(1, 1, 1, 1, 0, 0, 1, 15, 0, 1, 0);
    v(1, 0, 0, 1, 1, 15, 1, 5, 0, 0, 0);
    v(1, 0, 0, 1, 0, 0, 1, 15, 0, 1, 0);

    // MODULUS=10 random run against a reference model; dut10 sits in reset at 0
    m_o = 0;
    m_err = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      r    = ($urandom_range(0, 63) == 0);
      ce   = $urandom_range(0, 1) != 0;
      up   = $urandom_range(0, 1) != 0;
      ld   = ($urandom_range(0, 7) == 0);
      data = $urandom_range(0, 15);
      tc   = up ? (m_o == 9) : (m_o == 0);
      v(0, r, ce, up, ld, data, 1, m_o, m_err, tc, tc && ce && !ld && !r);
      if (r) begin
        m_o = 0;
        m_err = 1'b0;
      end else if (ld) begin
        if (data < 10) begin
          m_o = data;
        end else begin
          m_o = 9;
          m_err = 1'b1;
        end
      end else if (ce) begin
        if (up) m_o = (m_o == 9) ? 0 : m_o + 1;
        else    m_o = (m_o == 0) ? 9 : m_o - 1;
      end
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 8) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
